// File: rtl/conv_result_writer.sv
// Collects convolutor results, drops the pipeline-fill slots, requantizes each result to int8,
// and writes it to a channel-planar feature-map buffer with per-channel addressing.
module conv_result_writer #(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int NUM_CH       = 4,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        width,
  input  logic [7:0]        height,
  input  logic [2:0]        ch_count,
  input  logic [7:0]        fill_skip,
  input  logic [4:0]        shift,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              valid_in,
  input  logic [31:0]       conv_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              sat_flag
);

  localparam int PIX_W = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, SKIP, COLLECT, FINISH} state_t;
  state_t state, state_nxt;

  logic [7:0]        width_r, height_r, skip_r;
  logic [2:0]        ch_cnt_r;
  logic [4:0]        shift_r;
  logic [ADDR_W-1:0] base_r;

  logic [CH_W-1:0]   ch_idx;
  logic [7:0]        slot_cnt;
  logic [PIX_W-1:0]  pix_idx;

  logic [15:0]       npix;
  logic [18:0]       ch_off;
  logic              accept_start, degenerate, beat, collect_beat;
  logic              slot_done, skip_last, pix_last;

  logic signed [32:0] ext, rnd, sum, q;
  logic [7:0]         q8;
  logic               q_sat;

  assign npix         = 16'(width_r) * 16'(height_r);
  assign ch_off       = 19'(ch_idx) * 19'(npix);
  assign accept_start = (state == IDLE) && start;
  assign degenerate   = (width == 8'd0) || (height == 8'd0) || (ch_count == 3'd0);
  assign beat         = valid_in && ((state == SKIP) || (state == COLLECT));
  assign collect_beat = valid_in && (state == COLLECT);
  assign slot_done    = beat && (ch_idx == CH_W'(ch_cnt_r - 3'd1));
  assign skip_last    = (slot_cnt == skip_r - 8'd1);
  assign pix_last     = (pix_idx == PIX_W'(npix - 16'd1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (degenerate)            state_nxt = FINISH;
          else if (fill_skip != '0)  state_nxt = SKIP;
          else                       state_nxt = COLLECT;
        end
      end
      SKIP:    if (slot_done && skip_last) state_nxt = COLLECT;
      COLLECT: if (slot_done && pix_last)  state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FINISH coincides with the registered last write, so done lines up with that wr_en
  always_comb begin
    busy = (state != IDLE);
    done = (state == FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      width_r  <= '0;
      height_r <= '0;
      skip_r   <= '0;
      ch_cnt_r <= '0;
      shift_r  <= '0;
      base_r   <= '0;
    end else if (accept_start) begin
      width_r  <= width;
      height_r <= height;
      skip_r   <= fill_skip;
      ch_cnt_r <= ch_count;
      shift_r  <= shift;
      base_r   <= base_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || accept_start) begin
      ch_idx   <= '0;
      slot_cnt <= '0;
      pix_idx  <= '0;
    end else if (beat) begin
      ch_idx <= slot_done ? '0 : ch_idx + CH_W'(1);
      if (slot_done) begin
        if (state == SKIP) slot_cnt <= slot_cnt + 8'd1;
        else               pix_idx  <= pix_idx + PIX_W'(1);
      end
    end
  end

  // 33-bit intermediate keeps the rounding add from overflowing near the int32 limits
  always_comb begin
    ext   = $signed({conv_in[31], conv_in});
    rnd   = '0;
    if (shift_r != 5'd0) rnd = 33'sd1 <<< (shift_r - 5'd1);
    sum   = ext + rnd;
    q     = sum >>> shift_r;
    q8    = q[7:0];
    q_sat = 1'b0;
    if (q > 33'sd127) begin
      q8    = 8'h7f;
      q_sat = 1'b1;
    end else if (q < -33'sd128) begin
      q8    = 8'h80;
      q_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      sat_flag <= 1'b0;
    end else begin
      wr_en <= collect_beat;
      if (collect_beat) begin
        wr_addr <= base_r + ADDR_W'(ch_off) + ADDR_W'(pix_idx);
        wr_data <= q8;
      end
      if (accept_start)               sat_flag <= 1'b0;
      else if (collect_beat && q_sat) sat_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer: a stream-level model predicts every write, done and busy
// cycle, and literal expectations pin the model's arithmetic.
module tb_conv_result_writer;

  logic        clk = 1'b0;
  logic        rst, start, valid_in;
  logic [7:0]  width, height, fill_skip;
  logic [2:0]  ch_count;
  logic [4:0]  shift;
  logic [15:0] base_addr;
  logic [31:0] conv_in;
  logic        wr_en, busy, done, sat_flag;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  conv_result_writer #(
    .IMAGE_WIDTH (128),
    .IMAGE_HEIGHT(128),
    .NUM_CH      (4),
    .ADDR_W      (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .width    (width),
    .height   (height),
    .ch_count (ch_count),
    .fill_skip(fill_skip),
    .shift    (shift),
    .base_addr(base_addr),
    .valid_in (valid_in),
    .conv_in  (conv_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t  expq[$];
  wr_t  e_chk;
  bit   en_exp;
  bit   chk_on = 1'b0;

  int   m_w, m_h, m_ch, m_sk, m_sh, m_base, m_beat, m_layer_base;
  bit   m_active = 1'b0;
  bit   m_sat = 1'b0;
  int   m_busy_start = -1;
  int   m_busy_end = -1;
  int   m_done_cyc = -1;

  int          nwr = 0;
  logic [15:0] log_addr[0:1023];
  logic [7:0]  log_data[0:1023];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Unsaturated requantized value: round half up, then arithmetic shift
  function automatic longint rq(input longint v, input int s);
    if (s == 0) return v;
    return (v + (longint'(1) <<< (s - 1))) >>> s;
  endfunction

  function automatic int q_model(input longint v, input int s);
    longint r;
    r = rq(v, s);
    if (r > 127)  return 127;
    if (r < -128) return -128;
    return int'(r);
  endfunction

  function automatic logic [15:0] addr_model(input int base, input int ch, input int npix,
                                             input int pix);
    return 16'(base + ch * npix + pix);
  endfunction

  function automatic bit exp_busy_at(input int c);
    return (m_busy_start >= 0) && (c >= m_busy_start) && ((m_busy_end < 0) || (c <= m_busy_end));
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      en_exp = (expq.size() > 0) && (expq[0].due == cyc);
      check("wr_en", wr_en, en_exp);
      if (en_exp) begin
        e_chk = expq.pop_front();
        if (wr_en) begin
          check("wr_addr", wr_addr, e_chk.addr);
          check("wr_data", $signed(wr_data), $signed(e_chk.data));
        end
      end
      if (wr_en) begin
        if (nwr < 1024) begin
          log_addr[nwr] = wr_addr;
          log_data[nwr] = wr_data;
        end
        nwr++;
      end
      check("done", done, cyc == m_done_cyc);
      check("busy", busy, exp_busy_at(cyc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic do_start(input int w, input int h, input int ch, input int sk, input int sh,
                          input int base);
    width     = 8'(w);
    height    = 8'(h);
    ch_count  = 3'(ch);
    fill_skip = 8'(sk);
    shift     = 5'(sh);
    base_addr = 16'(base);
    start     = 1'b1;
    if (!exp_busy_at(cyc)) begin
      m_w = w; m_h = h; m_ch = ch; m_sk = sk; m_sh = sh; m_base = base;
      m_beat       = 0;
      m_layer_base = nwr;
      m_sat        = 1'b0;
      m_busy_start = cyc + 1;
      m_busy_end   = -1;
      m_done_cyc   = -1;
      m_active     = (w != 0) && (h != 0) && (ch != 0);
      if (!m_active) begin
        m_done_cyc = cyc + 1;
        m_busy_end = cyc + 1;
      end
    end
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int v);
    wr_t e_in;
    int  j, npix;
    longint r;
    valid_in = 1'b1;
    conv_in  = v;
    if (m_active) begin
      npix = m_w * m_h;
      if (m_beat >= m_sk * m_ch) begin
        j         = m_beat - m_sk * m_ch;
        e_in.due  = cyc + 1;
        e_in.addr = addr_model(m_base, j % m_ch, npix, j / m_ch);
        e_in.data = 8'(q_model(v, m_sh));
        expq.push_back(e_in);
        r = rq(v, m_sh);
        if (r > 127 || r < -128) m_sat = 1'b1;
        if (j == m_ch * npix - 1) begin
          m_active   = 1'b0;
          m_done_cyc = cyc + 1;
          m_busy_end = cyc + 1;
        end
      end
      m_beat++;
    end
    tick();
    valid_in = 1'b0;
  endtask

  // Reset with a live beat on the bus: the beat must be lost and the layer abandoned
  task automatic do_reset(input int v);
    rst      = 1'b1;
    valid_in = 1'b1;
    conv_in  = v;
    if (exp_busy_at(cyc)) m_busy_end = cyc;
    if (m_done_cyc > cyc) m_done_cyc = -1;
    m_active = 1'b0;
    m_sat    = 1'b0;
    tick();
    rst      = 1'b0;
    valid_in = 1'b0;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat_flag, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid_in = 1'b0; conv_in = '0;
    width = '0; height = '0; ch_count = '0; fill_skip = '0; shift = '0; base_addr = '0;
    tick();
    tick();
    chk_on = 1'b1;
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", wr_data, 0);
    check("reset_sat", sat_flag, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    tick();

    check("lit_q_sat_hi", q_model(3699, 0), 127);
    check("lit_q_sat_lo", q_model(-500, 0), -128);
    check("lit_q_544_s3", q_model(544, 3), 68);
    check("lit_q_m5_s1", q_model(-5, 1), -2);
    check("lit_q_5_s1", q_model(5, 1), 3);
    check("lit_addr_c2p3", addr_model('h100, 2, 16, 3), 'h123);

    // Plain 4x4 single-channel layer
    do_start(4, 4, 1, 5, 0, 0);
    for (int i = 0; i < 21; i++) beat(i);
    gap(3);
    check("s1_writes", nwr - m_layer_base, 16);
    check("s1_addr0", log_addr[m_layer_base], 0);
    check("s1_data0", log_data[m_layer_base], 5);
    check("s1_addr15", log_addr[m_layer_base + 15], 15);
    check("s1_data15", log_data[m_layer_base + 15], 20);
    check("s1_sat", sat_flag, 0);

    // Saturation at both rails; flag must stick until the next start
    do_start(4, 4, 1, 5, 0, 0);
    for (int i = 0; i < 21; i++) beat(i == 5 ? 3699 : (i == 6 ? -500 : i));
    gap(3);
    check("s2_sat", sat_flag, 1);
    check("s2_sat_model", sat_flag, m_sat);
    check("s2_data0", $signed(log_data[m_layer_base]), 127);
    check("s2_data1", $signed(log_data[m_layer_base + 1]), -128);
    gap(5);
    check("s2_sat_held", sat_flag, 1);

    // Rounding shifts, no fill slots
    do_start(1, 1, 1, 0, 3, 0);
    check("s3_sat_cleared", sat_flag, 0);
    beat(544);
    gap(3);
    check("s3_544", $signed(log_data[m_layer_base]), 68);
    do_start(2, 1, 1, 0, 1, 0);
    beat(-5);
    beat(5);
    gap(3);
    check("s3_m5", $signed(log_data[m_layer_base]), -2);
    check("s3_p5", $signed(log_data[m_layer_base + 1]), 3);
    check("s3_sat", sat_flag, 0);
    do_start(2, 1, 1, 0, 31, 0);
    beat(32'h7fffffff);
    beat(int'(32'h80000000));
    gap(3);
    check("s3_max_s31", $signed(log_data[m_layer_base]), 1);
    check("s3_min_s31", $signed(log_data[m_layer_base + 1]), -1);

    // Four interleaved channels, a start while busy, and a beat landing in FINISH
    do_start(4, 4, 4, 5, 0, 'h100);
    for (int k = 0; k < 84; k++) begin
      beat(k % 100 - 40);
      if (k == 40) do_start(2, 2, 1, 0, 0, 0);
    end
    beat(99);
    gap(3);
    check("s4_writes", nwr - m_layer_base, 64);
    check("s4_addr_c2p3", log_addr[m_layer_base + 14], 'h123);
    check("s4_addr_last", log_addr[m_layer_base + 63], 'h13f);

    // Random stalls between beats
    do_start(4, 4, 1, 5, 0, 0);
    for (int i = 0; i < 21; i++) begin
      beat(i);
      gap($urandom_range(0, 3));
    end
    gap(3);
    check("s5_writes", nwr - m_layer_base, 16);
    check("s5_data15", log_data[m_layer_base + 15], 20);

    // Reset right after write 7, then a clean layer
    do_start(4, 4, 1, 5, 0, 0);
    for (int i = 0; i < 13; i++) beat(i);
    do_reset(13);
    for (int i = 14; i < 21; i++) beat(i);
    gap(2);
    check("s6_writes_before_rst", nwr - m_layer_base, 8);
    do_start(4, 4, 1, 5, 0, 0);
    for (int i = 0; i < 21; i++) beat(i);
    gap(3);
    check("s6_restart_writes", nwr - m_layer_base, 16);
    check("s6_restart_data15", log_data[m_layer_base + 15], 20);

    // Degenerate layer finishes at once with no writes
    do_start(0, 4, 1, 5, 0, 0);
    beat(1);
    beat(2);
    gap(2);
    check("s7_writes", nwr - m_layer_base, 0);

    check("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_result_writer.md
Name: conv_result_writer

Overview:
- Receiving end of the convolutor3x3 output stream: `pixel_out` results go to a layer buffer.
- Discards the pipeline-fill slots produced while the line window primes.
- Requantizes each 32-bit accumulation to int8 (rounding shift plus saturation).
- Writes results to a flat feature-map memory, channel-planar, with per-channel address generation.
- Supports up to NUM_CH time-multiplexed output channels interleaved per pixel slot, the same schedule the layer sequencer uses when cycling weight sets.

Parameters:
- IMAGE_WIDTH, 128, maximum supported image width (sizes counters).
- IMAGE_HEIGHT, 128, maximum supported image height.
- NUM_CH, 4, maximum interleaved output channels per pixel slot.
- ADDR_W, 16, write-address width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that arms a new layer; sampled only in IDLE.
- width  in  8  runtime image width (1..IMAGE_WIDTH).
- height  in  8  runtime image height (1..IMAGE_HEIGHT).
- ch_count  in  3  interleaved channels per pixel slot (1..NUM_CH).
- fill_skip  in  8  leading pixel slots to discard (normally width+1).
- shift  in  5  requantization right-shift amount (0..31).
- base_addr  in  ADDR_W  buffer address of channel 0, pixel 0.
- valid_in  in  1  conv_in holds a valid result this cycle.
- conv_in  in  32  signed convolutor result.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  buffer write address.
- wr_data  out  8  signed requantized result.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- sat_flag  out  1  sticky flag: at least one result saturated this layer.

Behaviour:
- Reset: state=IDLE; all counters 0; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, sat_flag=0.
  - Reset mid-layer aborts immediately; no further writes occur and no done pulse is produced.
- States: IDLE, SKIP, COLLECT, FINISH.
- IDLE:
  - start=1 latches width, height, ch_count, fill_skip, shift and base_addr; clears sat_flag; sets busy=1.
  - Next state is SKIP if fill_skip>0, else COLLECT.
  - Degenerate start (width=0, height=0 or ch_count=0) goes straight to FINISH; no writes are produced.
  - valid_in in IDLE is ignored.
- Slot counting (applies in SKIP and COLLECT):
  - ch_idx increments on each valid_in beat and wraps at ch_count-1.
  - A pixel slot completes on the beat where ch_idx==ch_count-1.
  - valid_in=0 stalls all counters; gaps of any length are legal.
- SKIP: beats are discarded. When fill_skip slots have completed, go to COLLECT with ch_idx=0 and pix_idx=0.
- COLLECT, per valid beat:
  - shift=0: q = conv_in.
  - shift>0: q = (conv_in + 2^(shift-1)) >>> shift, using a 33-bit signed intermediate so the rounding add cannot overflow.
  - Saturate q to [-128, 127]; set sat_flag whenever clamping occurs.
  - Address = base_addr + ch_idx*width*height + pix_idx, computed modulo 2^ADDR_W (wraps silently).
  - Write latency is 1 cycle: wr_en, wr_addr and wr_data are registered and valid the cycle after the accepted beat. wr_en=0 on all other cycles.
  - pix_idx increments when a slot completes. When the slot with pix_idx==width*height-1 completes, go to FINISH.
- FINISH:
  - Entered the cycle the last write is issued; done=1 there (same cycle as the last wr_en), busy=0 from the following cycle.
  - State returns to IDLE the following cycle.
  - Beats arriving in FINISH are dropped.
- start while busy is ignored. start and rst in the same cycle: rst wins.
- width*height uses a 16-bit product; ch_idx*width*height uses a 19-bit product before truncation to ADDR_W.

Test Plan:
- width=4, height=4, ch_count=1, fill_skip=5, shift=0, base=0: 21 beats with values 0..20 -> 16 writes, addr 0..15, data 5..20; done asserted the same cycle as the addr-15 write.
- Same setup with conv_in=3699 then -500 at pixels 0 and 1 -> data 127 and -128; sat_flag=1 and held until the next start.
- shift=3, conv_in=544 -> 68; shift=1, conv_in=-5 -> -2; shift=1, conv_in=5 -> 3; sat_flag stays 0.
- ch_count=4, width=4, height=4, base=0x100: beat for channel 2, pixel 3 -> wr_addr=0x123; 64 writes total, one done pulse.
- Random valid_in gaps of 0..3 cycles with the scenario-1 stream -> identical write sequence; each write lands exactly 1 cycle after its beat.
- rst asserted after write 7 -> no further writes, all outputs 0; a fresh start then completes normally. start pulsed while busy -> no effect.
